pipeline_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB).

---
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush scheduler: merges per-stage stall requests, sequences exception
// flushes (deferred while MEM is blocked) and watches for stalls that never end.
module pipeline_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned WDOG_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_target,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  stall_timeout
);

  typedef enum logic [1:0] {
    StRun,
    StWaitFlush,
    StFlush
  } state_e;

  localparam logic [WDOG_WIDTH-1:0] WdogMax = WDOG_WIDTH'(WDOG_CYCLES);
  localparam logic [5:0] ExcHold = 6'b011111;

  state_e                  state_q, state_d;
  logic [5:0]              merge_stall;
  logic                    accept;
  logic                    flush_q;
  logic [ADDR_WIDTH-1:0]   flush_pc_q;
  logic [WDOG_WIDTH-1:0]   wdog_q, wdog_d;
  logic                    timeout_q;

  // The oldest stalled stage freezes every younger stage behind it.
  always_comb begin
    merge_stall = 6'b000000;
    if (stall_req_mem) begin
      merge_stall = 6'b011111;
    end else if (stall_req_ex) begin
      merge_stall = 6'b001111;
    end else if (stall_req_id) begin
      merge_stall = 6'b000111;
    end else if (stall_req_if) begin
      merge_stall = 6'b000011;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall   = merge_stall;
    unique case (state_q)
      StRun: begin
        if (exc_req) begin
          accept  = 1'b1;
          stall   = ExcHold;
          state_d = stall_req_mem ? StWaitFlush : StFlush;
        end
      end
      StWaitFlush: begin
        stall = ExcHold;
        if (!stall_req_mem) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        stall   = 6'b000000;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    if (rst) begin
      stall = 6'b000000;
    end
  end

  always_comb begin
    wdog_d = '0;
    if (stall[0]) begin
      wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= (state_d == StFlush);
      wdog_q    <= wdog_d;
      timeout_q <= (wdog_d == WdogMax);
      if (accept) begin
        flush_pc_q <= exc_target;
      end
    end
  end

  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stall-merge vectors, exception/watchdog/reset
// sequences and a randomized run against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned Wdog = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        exc_req;
  logic [31:0] exc_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_pending;
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_count;
  logic [5:0]  last_stall;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .ADDR_WIDTH (32),
    .WDOG_CYCLES(Wdog),
    .WDOG_WIDTH (11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_if (req_if),
    .stall_req_id (req_id),
    .stall_req_ex (req_ex),
    .stall_req_mem(req_mem),
    .exc_req      (exc_req),
    .exc_target   (exc_target),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall_timeout(stall_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Highest requesting stage k stalls stages 0..k.
  function automatic logic [5:0] model_stall(input bit r, input bit fi, input bit fd,
                                             input bit fe, input bit fm, input bit ex);
    int k;
    if (r || m_flush) return 6'b0;
    if (m_pending || ex) return 6'b011111;
    k = 0;
    if (fi) k = 1;
    if (fd) k = 2;
    if (fe) k = 3;
    if (fm) k = 4;
    if (k == 0) return 6'b0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic model_next(input bit r, input bit fm, input bit ex, input logic [31:0] tgt,
                            input logic [5:0] s);
    if (r) begin
      m_pending = 0; m_flush = 0; m_pc = '0; m_count = 0;
      return;
    end
    m_count = s[0] ? ((m_count < Wdog) ? m_count + 1 : Wdog) : 0;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_pending) begin
      if (!fm) begin
        m_pending = 0;
        m_flush   = 1;
      end
    end else if (ex) begin
      m_pc = tgt;
      if (fm) m_pending = 1;
      else    m_flush   = 1;
    end
  endtask

  // One clock: drive, check combinational stall, clock, check registered outputs.
  task automatic cyc(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                     input bit ex, input logic [31:0] tgt);
    logic [5:0] es;
    rst = r; req_if = fi; req_id = fd; req_ex = fe; req_mem = fm;
    exc_req = ex; exc_target = tgt;
    #3;
    es = model_stall(r, fi, fd, fe, fm, ex);
    last_stall = stall;
    check("stall", stall, es);
    model_next(r, fm, ex, tgt, es);
    @(posedge clk);
    #1;
    check("flush", flush, m_flush);
    check("stall_timeout", stall_timeout, (m_count == Wdog));
    if (m_flush) check("flush_pc", flush_pc, m_pc);
  endtask

  typedef struct {
    bit [3:0]   req;  // {if, id, ex, mem}
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'b0000, 6'b000000};
    vecs[1]  = '{4'b1000, 6'b000011};
    vecs[2]  = '{4'b0100, 6'b000111};
    vecs[3]  = '{4'b0010, 6'b001111};
    vecs[4]  = '{4'b0001, 6'b011111};
    vecs[5]  = '{4'b0101, 6'b011111};
    vecs[6]  = '{4'b0100, 6'b000111};
    vecs[7]  = '{4'b1010, 6'b001111};
    vecs[8]  = '{4'b1100, 6'b000111};
    vecs[9]  = '{4'b1111, 6'b011111};
    vecs[10] = '{4'b0011, 6'b011111};
    vecs[11] = '{4'b0000, 6'b000000};

    m_pending = 0; m_flush = 0; m_pc = '0; m_count = 0;
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 1, 1, 1, 1, 32'h1234);
    check("reset stall", last_stall, 6'b0);
    check("reset flush", flush, 1'b0);
    check("reset flush_pc", flush_pc, 32'h0);
    check("reset timeout", stall_timeout, 1'b0);

    foreach (vecs[i]) begin
      cyc(0, vecs[i].req[3], vecs[i].req[2], vecs[i].req[1], vecs[i].req[0], 0, 32'h0);
      check($sformatf("vec%0d stall", i), last_stall, vecs[i].exp);
    end

    // Exception with MEM free: flush one cycle later
    cyc(0, 1, 0, 0, 0, 1, 32'hBFC00380);
    check("t3 accept stall", last_stall, 6'b011111);
    check("t3 flush", flush, 1'b1);
    check("t3 flush_pc", flush_pc, 32'hBFC00380);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    check("t3 flush-cycle stall", last_stall, 6'b0);
    check("t3 flush drop", flush, 1'b0);

    // Exception deferred behind a blocked MEM; second exception ignored
    cyc(0, 0, 0, 0, 1, 1, 32'hBFC00380);
    check("t4 accept stall", last_stall, 6'b011111);
    check("t4 no early flush", flush, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, (i == 1), 32'h80000180);
      check("t4 wait stall", last_stall, 6'b011111);
      check("t4 wait flush", flush, 1'b0);
    end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    check("t4 release stall", last_stall, 6'b011111);
    check("t4 flush", flush, 1'b1);
    check("t4 flush_pc", flush_pc, 32'hBFC00380);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    check("t4 flush drop", flush, 1'b0);

    // Watchdog
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 1; i <= Wdog; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 32'h0);
      if (i == Wdog - 1) check("t5 timeout early", stall_timeout, 1'b0);
      if (i == Wdog) check("t5 timeout", stall_timeout, 1'b1);
    end
    cyc(0, 0, 0, 1, 0, 0, 32'h0);
    check("t5 timeout saturated", stall_timeout, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    check("t5 timeout clear", stall_timeout, 1'b0);

    // Reset mid WAIT_FLUSH discards the pending exception
    cyc(0, 0, 0, 0, 1, 1, 32'hDEAD0000);
    cyc(0, 0, 0, 0, 1, 0, 32'h0);
    cyc(1, 0, 0, 0, 1, 0, 32'h0);
    check("t6 rst stall", last_stall, 6'b0);
    check("t6 rst flush", flush, 1'b0);
    check("t6 rst flush_pc", flush_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 32'h0);
      check("t6 post stall", last_stall, 6'b0);
      check("t6 post flush", flush, 1'b0);
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
          ($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
          $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
